// File: rtl/soc_system_pio_shift_out_if.sv
// Parallel-in / serial-out link between a PIO out_port and a 74HC595-style
// shift register: parallel side inputs plus the registered serial outputs.
interface soc_system_pio_shift_out_if;
  logic [7:0] data_in;
  logic       refresh;
  logic       ser_clk;
  logic       ser_data;
  logic       ser_latch;
  logic       busy;

  modport master (
    output data_in,
    output refresh,
    input  ser_clk,
    input  ser_data,
    input  ser_latch,
    input  busy
  );

  modport slave (
    input  data_in,
    input  refresh,
    output ser_clk,
    output ser_data,
    output ser_latch,
    output busy
  );
endinterface

// File: rtl/soc_system_pio_shift_out.sv
// Serialises the PIO byte MSB first into a 74HC595-style register whenever it
// changes, on refresh, or once after reset, then pulses the storage latch.
module soc_system_pio_shift_out #(
  parameter int CLK_DIV = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  soc_system_pio_shift_out_if.slave   pio
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_t;

  localparam logic [7:0] HALF_M1 = 8'(CLK_DIV - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] sent_q, sent_d;
  logic       init_q, init_d;
  logic       ser_clk_q, ser_clk_d;
  logic       ser_data_q, ser_data_d;
  logic       ser_latch_q, ser_latch_d;
  logic       busy_q, busy_d;
  logic       frame_req_s;
  logic       phase_end_s;

  assign frame_req_s = (pio.data_in != sent_q) || pio.refresh || init_q;
  assign phase_end_s = (cnt_q == 8'd0);

  // Next-state and next-output computation; outputs are loaded one cycle
  // ahead so the registered pins line up with the state they belong to.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    sent_d      = sent_q;
    init_d      = init_q;
    ser_clk_d   = ser_clk_q;
    ser_data_d  = ser_data_q;
    ser_latch_d = ser_latch_q;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        if (frame_req_s) begin
          shift_d     = pio.data_in;
          sent_d      = pio.data_in;
          init_d      = 1'b0;
          bit_d       = 3'd0;
          cnt_d       = HALF_M1;
          busy_d      = 1'b1;
          ser_clk_d   = 1'b0;
          ser_data_d  = pio.data_in[7];
          ser_latch_d = 1'b0;
          state_d     = SHIFT_LO;
        end else begin
          busy_d      = 1'b0;
          ser_clk_d   = 1'b0;
          ser_data_d  = 1'b0;
          ser_latch_d = 1'b0;
        end
      end

      SHIFT_LO: begin
        if (phase_end_s) begin
          cnt_d     = HALF_M1;
          ser_clk_d = 1'b1;
          state_d   = SHIFT_HI;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      SHIFT_HI: begin
        if (phase_end_s) begin
          shift_d   = {shift_q[6:0], 1'b0};
          bit_d     = bit_q + 3'd1;
          cnt_d     = HALF_M1;
          ser_clk_d = 1'b0;
          if (bit_q == 3'd7) begin
            ser_data_d  = 1'b0;
            ser_latch_d = 1'b1;
            state_d     = LATCH;
          end else begin
            // Present the next bit together with the falling shift clock.
            ser_data_d = shift_q[6];
            state_d    = SHIFT_LO;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      LATCH: begin
        if (phase_end_s) begin
          cnt_d       = 8'd0;
          busy_d      = 1'b0;
          ser_latch_d = 1'b0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      default: begin
        state_d     = IDLE;
        cnt_d       = 8'd0;
        busy_d      = 1'b0;
        ser_clk_d   = 1'b0;
        ser_data_d  = 1'b0;
        ser_latch_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame and re-arms the
  // one-shot init frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      bit_q       <= 3'd0;
      shift_q     <= 8'd0;
      sent_q      <= 8'd0;
      init_q      <= 1'b1;
      ser_clk_q   <= 1'b0;
      ser_data_q  <= 1'b0;
      ser_latch_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      sent_q      <= sent_d;
      init_q      <= init_d;
      ser_clk_q   <= ser_clk_d;
      ser_data_q  <= ser_data_d;
      ser_latch_q <= ser_latch_d;
      busy_q      <= busy_d;
    end
  end

  assign pio.ser_clk   = ser_clk_q;
  assign pio.ser_data  = ser_data_q;
  assign pio.ser_latch = ser_latch_q;
  assign pio.busy      = busy_q;

endmodule

// File: tb/tb_soc_system_pio_shift_out.sv
// Self-checking bench: a frame-schedule model predicts every output cycle for
// a CLK_DIV=2 and a CLK_DIV=1 instance; directed scenarios pin literal results.
module tb_soc_system_pio_shift_out;

  logic       clk = 1'b0;
  logic       rst [2];
  logic [7:0] din [2];
  logic       refr [2];
  logic [3:0] out_v [2];

  int n_pass  = 0;
  int n_total = 0;

  soc_system_pio_shift_out_if if0 ();
  soc_system_pio_shift_out_if if1 ();

  assign if0.data_in = din[0];
  assign if0.refresh = refr[0];
  assign if1.data_in = din[1];
  assign if1.refresh = refr[1];
  assign out_v[0] = {if0.busy, if0.ser_latch, if0.ser_clk, if0.ser_data};
  assign out_v[1] = {if1.busy, if1.ser_latch, if1.ser_clk, if1.ser_data};

  soc_system_pio_shift_out #(.CLK_DIV(2)) dut0 (.clk(clk), .reset_n(rst[0]), .pio(if0));
  soc_system_pio_shift_out #(.CLK_DIV(1)) dut1 (.clk(clk), .reset_n(rst[1]), .pio(if1));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic int dv(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  // Model: a frame is a schedule (start cycle, value); outputs follow from the offset.
  int         cyc = 0;
  bit         m_init [2];
  logic [7:0] m_sent [2];
  logic [7:0] m_val  [2];
  int         m_s    [2];
  int         m_free [2];
  bit         m_has  [2] = '{1'b0, 1'b0};

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!rst[i]) begin
        m_init[i] = 1'b1; m_sent[i] = 8'h00; m_free[i] = 0; m_has[i] = 1'b0;
      end else if (cyc >= m_free[i] && (din[i] != m_sent[i] || refr[i] || m_init[i])) begin
        m_val[i] = din[i]; m_sent[i] = din[i]; m_init[i] = 1'b0;
        m_s[i] = cyc; m_has[i] = 1'b1; m_free[i] = cyc + 17 * dv(i) + 1;
      end
    end
  end

  // Monitor state
  logic [3:0] prev [2]      = '{4'h0, 4'h0};
  logic [7:0] cap [2]       = '{8'h00, 8'h00};
  int pulses [2]            = '{0, 0};
  int last_pulses [2]       = '{0, 0};
  int hi_run [2]            = '{0, 0};
  int hi_min [2]            = '{255, 255};
  int hi_max [2]            = '{0, 0};
  int busy_run [2]          = '{0, 0};
  int last_busy_run [2]     = '{0, 0};
  int idle_run [2]          = '{0, 0};
  int last_gap [2]          = '{0, 0};
  int latch_run [2]         = '{0, 0};
  int last_latch_run [2]    = '{0, 0};
  logic [7:0] frames0 [$];
  logic [7:0] frames1 [$];

  // Per-cycle compare against the model plus waveform bookkeeping.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [3:0] v, p, e;
      int k, d, b;
      v = out_v[i]; p = prev[i]; d = dv(i); e = 4'h0;
      if (rst[i] && m_has[i] && cyc >= m_s[i] && cyc < m_s[i] + 17 * d) begin
        k = cyc - m_s[i];
        if (k < 16 * d) begin
          b = k / (2 * d);
          e = {1'b1, 1'b0, ((k % (2 * d)) >= d) ? 1'b1 : 1'b0, m_val[i][7 - b]};
        end else begin
          e = 4'b1100;
        end
      end
      chk($sformatf("cycle%0d_dut%0d_outs", cyc, i), int'(v), int'(e));

      if (v[3]) begin
        if (!p[3]) begin last_gap[i] = idle_run[i]; busy_run[i] = 0; end
        busy_run[i]++; idle_run[i] = 0;
      end else begin
        if (p[3]) last_busy_run[i] = busy_run[i];
        idle_run[i]++;
      end
      if (v[1] && !p[1]) begin cap[i] = {cap[i][6:0], v[0]}; pulses[i]++; hi_run[i] = 0; end
      if (v[1]) hi_run[i]++;
      if (!v[1] && p[1]) begin
        if (hi_run[i] < hi_min[i]) hi_min[i] = hi_run[i];
        if (hi_run[i] > hi_max[i]) hi_max[i] = hi_run[i];
      end
      if (v[2]) begin
        if (!p[2]) begin
          latch_run[i] = 0;
          if (i == 0) frames0.push_back(cap[i]); else frames1.push_back(cap[i]);
          last_pulses[i] = pulses[i]; pulses[i] = 0;
        end
        latch_run[i]++;
      end else if (p[2]) begin
        last_latch_run[i] = latch_run[i];
      end
      if (!rst[i]) begin cap[i] = 8'h00; pulses[i] = 0; end
      prev[i] = v;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int n01;
    rst[0] = 1'b0; rst[1] = 1'b0;
    din[0] = 8'h00; din[1] = 8'hFF;
    refr[0] = 1'b0; refr[1] = 1'b0;
    step(3);
    chk("reset_outs_dut0", int'(out_v[0]), 0);
    chk("reset_outs_dut1", int'(out_v[1]), 0);
    rst[0] = 1'b1; rst[1] = 1'b1;
    step(40);
    // Init frames: 0x00 at CLK_DIV=2, 0xFF at CLK_DIV=1
    chk("init_frames0", frames0.size(), 1);
    if (frames0.size() > 0) chk("init_val0", int'(frames0[0]), 8'h00);
    chk("init_busy34", last_busy_run[0], 34);
    chk("init_latch2", last_latch_run[0], 2);
    chk("idle_after_init", int'(out_v[0]), 0);
    chk("div1_frames", frames1.size(), 1);
    if (frames1.size() > 0) chk("div1_val", int'(frames1[0]), 8'hFF);
    chk("div1_busy17", last_busy_run[1], 17);
    chk("div1_latch1", last_latch_run[1], 1);
    chk("div1_pulses", last_pulses[1], 8);
    chk("div1_hi_min", hi_min[1], 1);
    chk("div1_hi_max", hi_max[1], 1);

    // Value change 0x00 -> 0xA5
    hi_min[0] = 255; hi_max[0] = 0;
    din[0] = 8'hA5;
    step(40);
    chk("a5_frames", frames0.size(), 2);
    if (frames0.size() > 1) chk("a5_bits", int'(frames0[1]), 8'hA5);
    chk("a5_pulses", last_pulses[0], 8);
    chk("a5_hi_min", hi_min[0], 2);
    chk("a5_hi_max", hi_max[0], 2);
    chk("a5_latch2", last_latch_run[0], 2);

    // Mid-frame data changes: only the latest value follows
    refr[0] = 1'b1; step(1); refr[0] = 1'b0;
    step(5);  din[0] = 8'h01;
    step(10); din[0] = 8'h02;
    step(80);
    chk("mid_frames", frames0.size(), 4);
    if (frames0.size() > 3) begin
      chk("mid_first", int'(frames0[2]), 8'hA5);
      chk("mid_latest", int'(frames0[3]), 8'h02);
    end
    chk("mid_gap1", last_gap[0], 1);
    n01 = 0;
    foreach (frames0[j]) if (frames0[j] == 8'h01) n01++;
    chk("never_sent_01", n01, 0);

    // Refresh resends once; refresh while busy is dropped
    din[0] = 8'h3C;
    step(40);
    chk("3c_frames", frames0.size(), 5);
    refr[0] = 1'b1; step(1); refr[0] = 1'b0;
    step(10);
    refr[0] = 1'b1; step(1); refr[0] = 1'b0;
    step(80);
    chk("refresh_frames", frames0.size(), 6);
    if (frames0.size() > 5) chk("refresh_val", int'(frames0[5]), 8'h3C);

    // Reset at bit 4 aborts without latching; init frame resends
    din[0] = 8'h77;
    step(18);
    chk("abort_at_bit4", pulses[0], 4);
    rst[0] = 1'b0;
    #1;
    chk("abort_outs_zero", int'(out_v[0]), 0);
    din[0] = 8'h81;
    step(3);
    rst[0] = 1'b1;
    step(40);
    chk("abort_frames", frames0.size(), 7);
    if (frames0.size() > 6) chk("abort_resend", int'(frames0[6]), 8'h81);
    chk("abort_busy34", last_busy_run[0], 34);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
